// File: rtl/snake_board_scanner.sv
// snake_board_scanner
// Snapshots the snake core's board state (food, length, segment locations) on
// request and streams all 256 board cells in address order over a valid/ready
// handshake, classifying each cell as empty, body, head or food.
// Optional feature: define SNAKE_SCANNER_COLLIDE_EN to build the head/body
// collision detector; otherwise Collision is tied low.

module snake_board_scanner (
    input  logic         Clk,
    input  logic         Reset_N,
    input  logic         Start,
    input  logic [7:0]   Food,
    input  logic [3:0]   Length,
    input  logic [127:0] Locations_Flat,
    output logic [7:0]   Cell_Addr,
    output logic [1:0]   Cell_Type,
    output logic         Cell_Valid,
    input  logic         Cell_Ready,
    output logic         Busy,
    output logic         Frame_Done,
    output logic         Collision
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] TYPE_EMPTY = 2'b00;
    localparam logic [1:0] TYPE_BODY  = 2'b01;
    localparam logic [1:0] TYPE_HEAD  = 2'b10;
    localparam logic [1:0] TYPE_FOOD  = 2'b11;

    state_t      state_q;
    logic [7:0]  food_q;
    logic [3:0]  length_q;
    logic [7:0]  seg_q [16];
    logic [7:0]  cell_addr_q;
    logic [1:0]  cell_type_q;
    logic        cell_valid_q;
    logic        busy_q;
    logic        frame_done_q;

    logic        handshake_d;
    logic        last_cell_d;
    logic        load_cell_d;
    logic [7:0]  next_addr_d;
    logic        head_hit_d;
    logic        body_hit_d;
    logic [1:0]  next_type_d;

    // Decide whether a new cell is presented at the coming edge and which
    // address it will be: cell 0 out of LATCH, otherwise the successor of the
    // cell just handshaken (address 255 ends the frame instead of wrapping).
    always_comb begin
        handshake_d = cell_valid_q & Cell_Ready;
        last_cell_d = (cell_addr_q == 8'd255);
        load_cell_d = 1'b0;
        next_addr_d = 8'd0;
        if (state_q == LATCH) begin
            load_cell_d = 1'b1;
            next_addr_d = 8'd0;
        end else if (state_q == SCAN && handshake_d && !last_cell_d) begin
            load_cell_d = 1'b1;
            next_addr_d = cell_addr_q + 8'd1;
        end
    end

    // Compare the upcoming address against the snapshot only; segments past
    // the snapshot length are skipped so their reset zeros never mark cell 0.
    always_comb begin
        head_hit_d = (next_addr_d == seg_q[0]);
        body_hit_d = 1'b0;
        for (int k = 1; k < 16; k++) begin
            if ((4'(k) <= length_q) && (next_addr_d == seg_q[k])) begin
                body_hit_d = 1'b1;
            end
        end
    end

    // Priority classification: head beats body beats food.
    always_comb begin
        next_type_d = TYPE_EMPTY;
        if (head_hit_d) begin
            next_type_d = TYPE_HEAD;
        end else if (body_hit_d) begin
            next_type_d = TYPE_BODY;
        end else if (next_addr_d == food_q) begin
            next_type_d = TYPE_FOOD;
        end
    end

    // Frame sequencer with snapshot capture and registered stream outputs.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q      <= IDLE;
            food_q       <= 8'd0;
            length_q     <= 4'd0;
            for (int k = 0; k < 16; k++) begin
                seg_q[k] <= 8'd0;
            end
            cell_addr_q  <= 8'd0;
            cell_type_q  <= TYPE_EMPTY;
            cell_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        food_q   <= Food;
                        length_q <= Length;
                        for (int k = 0; k < 16; k++) begin
                            seg_q[k] <= Locations_Flat[127 - 8*k -: 8];
                        end
                        busy_q   <= 1'b1;
                        state_q  <= LATCH;
                    end
                end
                LATCH: begin
                    cell_addr_q  <= next_addr_d;
                    cell_type_q  <= next_type_d;
                    cell_valid_q <= 1'b1;
                    state_q      <= SCAN;
                end
                SCAN: begin
                    if (handshake_d) begin
                        if (last_cell_d) begin
                            cell_valid_q <= 1'b0;
                            frame_done_q <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            cell_addr_q <= next_addr_d;
                            cell_type_q <= next_type_d;
                        end
                    end
                end
                DONE: begin
                    frame_done_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef SNAKE_SCANNER_COLLIDE_EN
    logic collision_q;

    // Sticky head-on-body flag; cleared as the frame enters LATCH so it reads
    // low during LATCH and holds its final value after Frame_Done.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            collision_q <= 1'b0;
        end else if (state_q == IDLE && Start) begin
            collision_q <= 1'b0;
        end else if (load_cell_d && head_hit_d && body_hit_d) begin
            collision_q <= 1'b1;
        end
    end

    assign Collision = collision_q;
`else
    assign Collision = 1'b0;
`endif

    assign Cell_Addr  = cell_addr_q;
    assign Cell_Type  = cell_type_q;
    assign Cell_Valid = cell_valid_q;
    assign Busy       = busy_q;
    assign Frame_Done = frame_done_q;

endmodule

// File: tb/tb_snake_board_scanner.sv
// tb_snake_board_scanner
// Directed bench for snake_board_scanner: reset values, full frames with the
// sink always ready, back-pressure, snapshot isolation, full-length snake,
// collision flag (with or without SNAKE_SCANNER_COLLIDE_EN) and mid-frame reset.

module tb_snake_board_scanner;

    logic         Clk;
    logic         Reset_N;
    logic         Start;
    logic [7:0]   Food;
    logic [3:0]   Length;
    logic [127:0] Locations_Flat;
    logic [7:0]   Cell_Addr;
    logic [1:0]   Cell_Type;
    logic         Cell_Valid;
    logic         Cell_Ready;
    logic         Busy;
    logic         Frame_Done;
    logic         Collision;

    int assertCount = 0;
    int failCount   = 0;

    int gotType [256];
    int expType [256];
    logic [7:0] segs [16];
    int doneEdge;
    int busyOffEdge;
    int donePulses;
    int collAtDone;

    snake_board_scanner dut (
        .Clk            (Clk),
        .Reset_N        (Reset_N),
        .Start          (Start),
        .Food           (Food),
        .Length         (Length),
        .Locations_Flat (Locations_Flat),
        .Cell_Addr      (Cell_Addr),
        .Cell_Type      (Cell_Type),
        .Cell_Valid     (Cell_Valid),
        .Cell_Ready     (Cell_Ready),
        .Busy           (Busy),
        .Frame_Done     (Frame_Done),
        .Collision      (Collision)
    );

    // Free-running 10 ns clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive the board inputs from the segs table.
    task automatic applyStimulus(input logic [7:0] food, input logic [3:0] len);
        for (int k = 0; k < 16; k++) begin
            Locations_Flat[127 - 8*k -: 8] = segs[k];
        end
        Food   = food;
        Length = len;
    endtask

    task automatic clearSegs();
        for (int k = 0; k < 16; k++) segs[k] = 8'd0;
    endtask

    task automatic clearExpected();
        for (int i = 0; i < 256; i++) expType[i] = 0;
    endtask

    // Run one frame from a Start pulse, optionally stalling the sink at one
    // address and optionally disturbing inputs / re-pulsing Start mid-frame.
    task automatic runFrame(input bit doStall, input logic [7:0] stallAddr, input int stallLen, input bit midChange);
        int cycle;
        int stalled;
        logic [7:0] heldAddr;
        logic [1:0] heldType;
        for (int i = 0; i < 256; i++) gotType[i] = -1;
        doneEdge    = -1;
        busyOffEdge = -1;
        donePulses  = 0;
        collAtDone  = -1;
        stalled     = 0;
        heldAddr    = 8'd0;
        heldType    = 2'd0;
        Cell_Ready  = 1'b1;
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        cycle = 0;
        checkOutput("busy_at_E", {31'd0, Busy}, 32'd1);
        checkOutput("valid_at_E", {31'd0, Cell_Valid}, 32'd0);
        if (midChange) begin
            Food   = 8'h10;
            Length = 4'd2;
        end
        while (busyOffEdge < 0 && cycle < 400) begin
            @(posedge Clk);
            #1;
            cycle++;
            if (Frame_Done) begin
                donePulses++;
                if (doneEdge < 0) begin
                    doneEdge   = cycle;
                    collAtDone = int'(Collision);
                end
            end
            if (!Busy) busyOffEdge = cycle;
            if (midChange) Start = (cycle == 100);
            if (doStall && Cell_Valid && Cell_Addr == stallAddr && stalled < stallLen) begin
                if (stalled == 0) begin
                    heldAddr = Cell_Addr;
                    heldType = Cell_Type;
                end else begin
                    checkOutput("stall_addr_hold", {24'd0, Cell_Addr}, {24'd0, heldAddr});
                    checkOutput("stall_type_hold", {30'd0, Cell_Type}, {30'd0, heldType});
                end
                stalled++;
                Cell_Ready = 1'b0;
            end else begin
                Cell_Ready = 1'b1;
                if (Cell_Valid) gotType[Cell_Addr] = int'(Cell_Type);
            end
        end
        Start      = 1'b0;
        Cell_Ready = 1'b1;
    endtask

    // Compare the captured frame with the hand-built expectation table.
    task automatic checkFrame(input string tag);
        int bad;
        int firstBad;
        bad = 0;
        firstBad = -1;
        for (int i = 0; i < 256; i++) begin
            if (gotType[i] != expType[i]) begin
                bad++;
                if (firstBad < 0) firstBad = i;
            end
        end
        if (bad != 0) $display("[TB] %s first differing cell %0d: got %0d want %0d", tag, firstBad, gotType[firstBad], expType[firstBad]);
        checkOutput({tag, "_bad_cells"}, bad, 0);
    endtask

    task automatic checkIdleStays(input string tag, input int cycles);
        int busySeen;
        busySeen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge Clk);
            #1;
            if (Busy || Frame_Done || Cell_Valid) busySeen++;
        end
        checkOutput(tag, busySeen, 0);
    endtask

    initial begin
        int waitCount;
        Reset_N        = 1'b0;
        Start          = 1'b0;
        Cell_Ready     = 1'b1;
        Food           = 8'd0;
        Length         = 4'd0;
        Locations_Flat = '0;

        // Reset values
        #12;
        checkOutput("rst_addr",   {24'd0, Cell_Addr}, 32'd0);
        checkOutput("rst_type",   {30'd0, Cell_Type}, 32'd0);
        checkOutput("rst_valid",  {31'd0, Cell_Valid}, 32'd0);
        checkOutput("rst_busy",   {31'd0, Busy}, 32'd0);
        checkOutput("rst_done",   {31'd0, Frame_Done}, 32'd0);
        checkOutput("rst_coll",   {31'd0, Collision}, 32'd0);
        @(negedge Clk);
        Reset_N = 1'b1;
        checkIdleStays("idle_after_reset", 5);

        // Initial board
        $display("[TB] initial board frame");
        clearSegs();
        segs[0] = 8'd125;
        segs[1] = 8'd124;
        applyStimulus(8'h37, 4'd1);
        clearExpected();
        expType[125] = 2;
        expType[124] = 1;
        expType[55]  = 3;
        runFrame(1'b0, 8'd0, 0, 1'b0);
        checkOutput("init_done_edge", doneEdge, 257);
        checkOutput("init_busy_off", busyOffEdge, 258);
        checkOutput("init_done_pulses", donePulses, 1);
        checkOutput("init_cell125", gotType[125], 2);
        checkOutput("init_cell124", gotType[124], 1);
        checkOutput("init_cell55", gotType[55], 3);
        checkOutput("init_cell0", gotType[0], 0);
        checkFrame("init");

        // Back-pressure at address 3
        $display("[TB] back-pressure frame");
        runFrame(1'b1, 8'd3, 5, 1'b0);
        checkOutput("bp_done_edge", doneEdge, 262);
        checkOutput("bp_busy_off", busyOffEdge, 263);
        checkOutput("bp_cell3", gotType[3], 0);
        checkFrame("bp");

        // Snapshot isolation and ignored mid-frame Start
        $display("[TB] snapshot frame");
        applyStimulus(8'h37, 4'd1);
        runFrame(1'b0, 8'd0, 0, 1'b1);
        checkOutput("snap_cell55", gotType[55], 3);
        checkOutput("snap_cell16", gotType[8'h10], 0);
        checkOutput("snap_cell124", gotType[124], 1);
        checkOutput("snap_done_edge", doneEdge, 257);
        checkFrame("snap");
        checkIdleStays("snap_start_not_queued", 10);

        // Full-length snake; food placed under the body
        $display("[TB] full length frame");
        for (int k = 0; k < 16; k++) segs[k] = 8'hF0 + 8'(k);
        applyStimulus(8'hF5, 4'd15);
        clearExpected();
        expType[8'hF0] = 2;
        for (int i = 8'hF1; i <= 8'hFF; i++) expType[i] = 1;
        runFrame(1'b0, 8'd0, 0, 1'b0);
        checkOutput("full_cellF0", gotType[8'hF0], 2);
        checkOutput("full_cellFF", gotType[8'hFF], 1);
        checkOutput("full_cellF5", gotType[8'hF5], 1);
        checkOutput("full_cell0", gotType[0], 0);
        checkFrame("full");

        // Head on body
        $display("[TB] collision frames");
        clearSegs();
        segs[0] = 8'h22;
        segs[1] = 8'h21;
        segs[2] = 8'h20;
        segs[3] = 8'h22;
        applyStimulus(8'h37, 4'd3);
        clearExpected();
        expType[8'h22] = 2;
        expType[8'h21] = 1;
        expType[8'h20] = 1;
        expType[55]    = 3;
        runFrame(1'b0, 8'd0, 0, 1'b0);
        checkOutput("coll_cell22", gotType[8'h22], 2);
        checkFrame("coll");
`ifdef SNAKE_SCANNER_COLLIDE_EN
        checkOutput("coll_flag_set", collAtDone, 1);
`else
        checkOutput("coll_flag_tied", collAtDone, 0);
`endif
        segs[3] = 8'h23;
        applyStimulus(8'h37, 4'd3);
        expType[8'h23] = 1;
        runFrame(1'b0, 8'd0, 0, 1'b0);
        checkOutput("nocoll_cell23", gotType[8'h23], 1);
        checkOutput("nocoll_flag", collAtDone, 0);
        checkFrame("nocoll");

        // Reset mid-frame at address 40
        $display("[TB] mid-frame reset");
        Cell_Ready = 1'b1;
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        waitCount = 0;
        while (!(Cell_Valid && Cell_Addr == 8'd40) && waitCount < 100) begin
            @(posedge Clk);
            #1;
            waitCount++;
        end
        Cell_Ready = 1'b0;
        checkOutput("pre_reset_addr", {24'd0, Cell_Addr}, 32'd40);
        #2;
        Reset_N = 1'b0;
        #1;
        checkOutput("midrst_addr",  {24'd0, Cell_Addr}, 32'd0);
        checkOutput("midrst_type",  {30'd0, Cell_Type}, 32'd0);
        checkOutput("midrst_valid", {31'd0, Cell_Valid}, 32'd0);
        checkOutput("midrst_busy",  {31'd0, Busy}, 32'd0);
        checkOutput("midrst_done",  {31'd0, Frame_Done}, 32'd0);
        checkOutput("midrst_coll",  {31'd0, Collision}, 32'd0);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset_N    = 1'b1;
        Cell_Ready = 1'b1;
        checkIdleStays("idle_20_after_midrst", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
